// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared types and constants for the boot-time program loader:
//   - state_t      : loader FSM states
//   - ERR_*        : err_code encodings reported on the err_code output
//   - LANE_*       : byte-lane indices inside an instruction slot
//   - next_lane()  : lane sequencing opcode -> op1 -> op2 -> opcode
// -----------------------------------------------------------------------------
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_COUNT   = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] LANE_OPC = 2'd0;
  localparam logic [1:0] LANE_OP1 = 2'd1;
  localparam logic [1:0] LANE_OP2 = 2'd2;

  // Lane 3 is never produced: operand 2 wraps straight back to the opcode lane.
  function automatic logic [1:0] next_lane(input logic [1:0] lane);
    return (lane == LANE_OP2) ? LANE_OPC : lane + 2'd1;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
// Bundles the loader's byte-stream input and its instruction-RAM write port.
//   in_data/in_valid/in_ready : valid/ready byte stream into the loader
//   wr_en/wr_addr/wr_lane/wr_data : registered byte-lane RAM write port
// Modports:
//   slave  : loader side (consumes the stream, drives the write port)
//   master : producer/observer side (drives the stream, watches the writes)
// -----------------------------------------------------------------------------
interface program_loader_if #(
  parameter int ADDR_W = 6
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_lane;
  logic [7:0]        wr_data;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_lane,
    output wr_data
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_lane,
    input  wr_data
  );

endinterface

// File: rtl/program_loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
// Idle-cycle counter for the loader. Counts cycles while enabled and not
// cleared; o_expired is high during the cycle in which the next idle edge
// would bring the count to TIMEOUT, so the owner can leave on that edge.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_clr      : clear the count (handshake seen or not in a transfer state)
//   i_en       : count enable (transfer state active)
//   o_expired  : TIMEOUT idle edges reached on the coming edge
// -----------------------------------------------------------------------------
module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_expired  = i_en && w_at_limit;

  // Saturates at the limit so the count never wraps if the owner lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Boot stage of the 8-bit CPU. Accepts a byte stream
//   header N, 3*N payload bytes (opcode, op1, op2 per slot), checksum
// writes each payload byte into instruction RAM by {slot, lane}, verifies the
// mod-256 payload sum against the checksum byte and releases the CPU only
// after a clean load.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a new load (honoured in IDLE, DONE, ERR)
//   bus        : stream input + RAM write port (program_loader_if.slave)
//   cpu_hold   : high keeps the CPU in reset
//   done       : one-cycle pulse on a successful load
//   load_ok    : level, last load succeeded
//   err        : level, last load failed
//   err_code   : 01 bad count, 10 checksum mismatch, 11 timeout
// -----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  program_loader_if.slave       bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  load_ok,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int MAX_N = 1 << ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_active;
  logic              w_hs;
  logic              w_hdr_bad;
  logic [8:0]        w_hdr_m1;
  logic              w_last_byte;
  logic              w_sum_ok;
  logic              w_tmo;
  logic              w_tmo_clr;
  logic              w_to_hdr;
  logic              w_set_err;
  logic [1:0]        w_err_code_nxt;

  logic [ADDR_W-1:0] r_slot;
  logic [ADDR_W-1:0] r_last;
  logic [1:0]        r_lane;
  logic [7:0]        r_sum;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_wr_lane;
  logic [7:0]        r_wr_data;
  logic              r_done;
  logic              r_load_ok;
  logic              r_err;
  logic [1:0]        r_err_code;

  assign w_active  = (r_state == HDR) || (r_state == PAYLOAD) || (r_state == CHK);
  assign w_hs      = bus.in_valid && w_active;

  // Header checks. N is kept as N-1 so the last slot index fits ADDR_W bits
  // even when N = 2^ADDR_W.
  assign w_hdr_bad   = (bus.in_data == 8'd0) || (int'(bus.in_data) > MAX_N);
  assign w_hdr_m1    = {1'b0, bus.in_data} - 9'd1;
  assign w_last_byte = (r_slot == r_last) && (r_lane == LANE_OP2);
  assign w_sum_ok    = (bus.in_data == r_sum);

  // Any handshake restarts the idle window; outside a transfer the counter
  // is held clear so every entry to HDR starts from zero.
  assign w_tmo_clr = !w_active || w_hs;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmo_clr),
    .i_en      (w_active),
    .o_expired (w_tmo)
  );

  // Next-state logic. A handshake always takes priority over a timeout that
  // expires on the same edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_to_hdr       = 1'b0;
    w_set_err      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_state_nxt = HDR;
          w_to_hdr    = 1'b1;
        end
      end
      HDR: begin
        if (w_hs) begin
          if (w_hdr_bad) begin
            w_state_nxt    = ERR;
            w_set_err      = 1'b1;
            w_err_code_nxt = ERR_COUNT;
          end else begin
            w_state_nxt = PAYLOAD;
          end
        end else if (w_tmo) begin
          w_state_nxt    = ERR;
          w_set_err      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      PAYLOAD: begin
        if (w_hs) begin
          if (w_last_byte) begin
            w_state_nxt = CHK;
          end
        end else if (w_tmo) begin
          w_state_nxt    = ERR;
          w_set_err      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      CHK: begin
        if (w_hs) begin
          if (w_sum_ok) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt    = ERR;
            w_set_err      = 1'b1;
            w_err_code_nxt = ERR_CSUM;
          end
        end else if (w_tmo) begin
          w_state_nxt    = ERR;
          w_set_err      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- stage p0 -> p1: slot/lane sequencing and running payload sum ----
  // Pure datapath; every field is re-initialised by the header handshake
  // before it is used.
  always_ff @(posedge clk) begin
    if ((r_state == HDR) && w_hs) begin
      r_slot <= '0;
      r_lane <= LANE_OPC;
      r_sum  <= 8'd0;
      r_last <= ADDR_W'(w_hdr_m1);
    end else if ((r_state == PAYLOAD) && w_hs) begin
      r_sum  <= r_sum + bus.in_data;
      r_lane <= next_lane(r_lane);
      if (r_lane == LANE_OP2) begin
        r_slot <= r_slot + ADDR_W'(1);
      end
    end
  end

  // ---- stage p1: registered RAM write port and status outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_lane  <= LANE_OPC;
      r_wr_data  <= 8'd0;
      r_done     <= 1'b0;
      r_load_ok  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if ((r_state == PAYLOAD) && w_hs) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_slot;
        r_wr_lane <= r_lane;
        r_wr_data <= bus.in_data;
      end
      if ((r_state == CHK) && w_hs && w_sum_ok) begin
        r_done    <= 1'b1;
        r_load_ok <= 1'b1;
      end
      if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code_nxt;
      end
      if (w_to_hdr) begin
        r_load_ok  <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  assign bus.in_ready = w_active;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_lane  = r_wr_lane;
  assign bus.wr_data  = r_wr_data;

  // The CPU runs only while the loader rests in DONE; any new load re-holds it.
  assign cpu_hold = (r_state != DONE);
  assign done     = r_done;
  assign load_ok  = r_load_ok;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic       load_ok;
  logic       err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .load_ok  (load_ok),
    .err      (err),
    .err_code (err_code)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [1:0]        l;
    logic [7:0]        d;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        sb[$];
  logic [7:0] pay [0:191];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-port scoreboard: every RAM write must match the oldest expectation.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_wr", 32'(bus.wr_en), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
          chk("wr_lane", 32'(bus.wr_lane), 32'(e.l));
          chk("wr_data", 32'(bus.wr_data), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no_finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    chk({tag, "_wr_lane"},  32'(bus.wr_lane),  32'd0);
    chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd1);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_load_ok"},  32'(load_ok),      32'd0);
    chk({tag, "_err"},      32'(err),          32'd0);
    chk({tag, "_err_code"}, 32'(err_code),     32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one byte and holds it until accepted; pushes the expected write
  // just before the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit push,
                           input logic [ADDR_W-1:0] a, input logic [1:0] l, input bit bp);
    int g;
    if (bp) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick();
      end
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (bus.in_ready === 1'b1) begin
        if (push) sb.push_back(wr_t'({a, l, d}));
        tick();
        bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] n, input int nbytes, input bit bp, input logic [7:0] cx);
    logic [7:0] s;
    s = 8'd0;
    send_byte(n, 1'b0, '0, 2'd0, bp);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(pay[i], 1'b1, ADDR_W'(i / 3), 2'(i % 3), bp);
      s = s + pay[i];
    end
    send_byte(s ^ cx, 1'b0, '0, 2'd0, bp);
  endtask

  task automatic set_nominal();
    pay[0] = 8'h01; pay[1] = 8'h0A; pay[2] = 8'h0B;
    pay[3] = 8'h02; pay[4] = 8'h0C; pay[5] = 8'h0D;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Nominal N=2 load, checksum 0x31
    set_nominal();
    pulse_start();
    chk("hdr_in_ready", 32'(bus.in_ready), 32'd1);
    run_load(8'd2, 6, 1'b0, 8'h00);
    chk("nom_done",     32'(done),     32'd1);
    chk("nom_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("nom_load_ok",  32'(load_ok),  32'd1);
    chk("nom_err",      32'(err),      32'd0);
    chk("nom_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("nom_done_pulse", 32'(done),        32'd0);
    chk("nom_load_ok_lv", 32'(load_ok),     32'd1);
    chk("nom_ready_low",  32'(bus.in_ready), 32'd0);

    // Bad counts: 0 and 2^ADDR_W + 1
    pulse_start();
    chk("bc_load_ok_clr", 32'(load_ok),  32'd0);
    chk("bc_cpu_hold",    32'(cpu_hold), 32'd1);
    send_byte(8'h00, 1'b0, '0, 2'd0, 1'b0);
    chk("bc0_err",      32'(err),          32'd1);
    chk("bc0_code",     32'(err_code),     32'd1);
    chk("bc0_ready",    32'(bus.in_ready), 32'd0);
    tick();
    pulse_start();
    chk("bc_err_clr",   32'(err),      32'd0);
    chk("bc_code_clr",  32'(err_code), 32'd0);
    send_byte(8'h41, 1'b0, '0, 2'd0, 1'b0);
    chk("bc41_err",     32'(err),      32'd1);
    chk("bc41_code",    32'(err_code), 32'd1);
    chk("bc_sb_empty",  32'(sb.size()), 32'd0);

    // Checksum mismatch 0x30
    set_nominal();
    pulse_start();
    run_load(8'd2, 6, 1'b0, 8'h01);
    chk("cs_err",      32'(err),      32'd1);
    chk("cs_code",     32'(err_code), 32'd2);
    chk("cs_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("cs_done",     32'(done),     32'd0);
    chk("cs_load_ok",  32'(load_ok),  32'd0);
    chk("cs_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure N=3 with random gaps
    for (int i = 0; i < 9; i++) pay[i] = 8'($urandom);
    pulse_start();
    run_load(8'd3, 9, 1'b1, 8'h00);
    chk("bp_done",     32'(done),     32'd1);
    chk("bp_load_ok",  32'(load_ok),  32'd1);
    chk("bp_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Timeout: stall after byte 4
    pulse_start();
    send_byte(8'd3, 1'b0, '0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i), 1'b1, '0, 2'(i), 1'b0);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet_err",   32'(err),          32'd0);
    chk("to_not_yet_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("to_err",      32'(err),          32'd1);
    chk("to_code",     32'(err_code),     32'd3);
    chk("to_ready",    32'(bus.in_ready), 32'd0);
    chk("to_cpu_hold", 32'(cpu_hold),     32'd1);
    chk("to_sb_empty", 32'(sb.size()),    32'd0);

    // Maximum program N=64, payload i mod 256
    for (int i = 0; i < 192; i++) pay[i] = 8'(i);
    pulse_start();
    run_load(8'd64, 192, 1'b0, 8'h00);
    chk("max_done",     32'(done),      32'd1);
    chk("max_load_ok",  32'(load_ok),   32'd1);
    chk("max_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    pulse_start();
    chk("rl_load_ok_clr", 32'(load_ok),  32'd0);
    chk("rl_cpu_hold",    32'(cpu_hold), 32'd1);
    run_load(8'd1, 3, 1'b0, 8'h00);
    chk("rl_done",    32'(done),    32'd1);
    chk("rl_load_ok", 32'(load_ok), 32'd1);

    // rst mid-PAYLOAD after byte 5
    tick();
    for (int i = 0; i < 12; i++) pay[i] = 8'($urandom);
    pulse_start();
    send_byte(8'd4, 1'b0, '0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(pay[i], 1'b1, ADDR_W'(i / 3), 2'(i % 3), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset("midrst");
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    set_nominal();
    pulse_start();
    run_load(8'd2, 6, 1'b0, 8'h00);
    chk("post_done",     32'(done),     32'd1);
    chk("post_load_ok",  32'(load_ok),  32'd1);
    chk("post_cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("post_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage of the 8-bit CPU. It receives a byte stream on a valid/ready interface and unpacks it into instruction slots (opcode, operand 1, operand 2). Each slot is written into the instruction RAM through a byte-lane write port. The CPU is held in reset until a complete, checksum-verified program has been written.

## Interface
Parameters:
- ADDR_W, 6, instruction-slot address width (matches the 6-bit PC)
- TIMEOUT, 1024, maximum idle cycles between accepted bytes during a transfer (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a new load; sampled only in IDLE, DONE or ERR
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  instruction slot index
- wr_lane  out  2  byte lane: 0 opcode, 1 operand 1, 2 operand 2 (3 never driven)
- wr_data  out  8  byte to write
- cpu_hold  out  1  high keeps the CPU in reset
- done  out  1  one-cycle pulse when a load completes successfully
- load_ok  out  1  level, last load succeeded
- err  out  1  level, last load failed
- err_code  out  2  01 bad count, 10 checksum mismatch, 11 timeout

## Operation
- Stream format: header byte N, then 3·N payload bytes in slot order (opcode, op1, op2), then one checksum byte.
- N must satisfy 1 ≤ N ≤ 2^ADDR_W.
- Checksum byte = 8-bit sum (mod 256) of the payload bytes. The header is not included.
- A handshake occurs when in_valid and in_ready are both high on a rising clk.
- States:
  - IDLE: in_ready=0. start → HDR.
  - HDR: in_ready=1. Accepted byte N: if N=0 or N>2^ADDR_W → ERR with code 01; otherwise store N, clear slot, lane and sum → PAYLOAD.
  - PAYLOAD: in_ready=1. Each accepted byte is written to {slot, lane} and added to sum. Lane advances 0→1→2→0; the slot increments when lane wraps. After byte 3·N is accepted → CHK.
  - CHK: in_ready=1. If accepted byte == sum → DONE; otherwise ERR with code 10.
  - DONE: in_ready=0, cpu_hold=0, load_ok=1. start → HDR.
  - ERR: in_ready=0, cpu_hold=1, err=1. start → HDR.
- Timeout: in HDR, PAYLOAD or CHK, TIMEOUT consecutive cycles without a handshake → ERR with code 11. The counter clears on every handshake and on state entry.
- Payload bytes written before a failure are not rolled back; the CPU stays held.
- start while in HDR, PAYLOAD or CHK is ignored.
- start clears load_ok, err and err_code on the transition to HDR.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_lane=0, wr_data=0, cpu_hold=1, done=0, load_ok=0, err=0, err_code=00. State is IDLE.
- start → HDR on the next edge; in_ready goes high in the following cycle.
- Writes are registered: a handshake on edge k produces wr_en=1 with that byte's addr/lane/data during the cycle after edge k. wr_en is never high for two cycles unless handshakes occur on consecutive edges.
- Back-to-back handshakes are supported at full rate, one byte per cycle, with no bubbles.
- The final payload write and the entry to CHK happen on the same edge.
- A CHK handshake on edge k → state DONE, done=1, cpu_hold=0 and load_ok=1 are all visible after edge k. done lasts exactly one cycle.
- Timeout fires on the edge where the idle count reaches TIMEOUT. If a handshake occurs on that same edge, the handshake wins.
- rst asserted at any time, including mid-transfer, returns all outputs to their reset values immediately. No partial write completes after rst.

## Structure
- Package program_loader_pkg: state enum (IDLE, HDR, PAYLOAD, CHK, DONE, ERR), err_code constants (ERR_NONE, ERR_COUNT, ERR_CSUM, ERR_TIMEOUT), lane constants.
- Sub-module loader_timeout: parameterised idle counter with clear/enable inputs and an expired output. It is instantiated once.
- Everything else (FSM, slot/lane counters, sum accumulator, registered write port) lives in program_loader.

## Test plan
- Nominal load: N=2, payload 01 0A 0B 02 0C 0D, checksum 0x31 → six writes to (0,0..2),(1,0..2) with the matching data, then done pulse, cpu_hold=0, load_ok=1.
- Bad count: header 0x00 → ERR, err_code=01, no wr_en. Then header 0x41 with ADDR_W=6 → err_code=01.
- Checksum mismatch: same stream as nominal with checksum 0x30 → all six writes occur, then err=1, err_code=10, cpu_hold stays 1.
- Timeout and backpressure: in_valid toggled randomly while N=3 loads correctly; a separate run stalls after byte 4 for TIMEOUT cycles → err_code=11 exactly at cycle TIMEOUT.
- Max program and wrap: N=64, payload byte i = i mod 256 → last write goes to slot 63, lane 2, and the checksum is computed mod 256. Then start reloads N=1 and load_ok clears and re-sets.
- rst mid-PAYLOAD after byte 5 → all outputs return to reset values at once. A subsequent full load succeeds.
